prio_rr_arb: RTL and testbench
==============================

Name: prio_rr_arb

Overview:
- N-master to 1-slave arbiter with a PW-bit priority level per master.
- Registered, one-hot grant.
- Among masters that share the highest priority, the tie is broken either by lowest index or by a round-robin pointer, selected by a parameter.
- A grant is locked for the whole transfer and is released on the last beat or when the owner drops its request. It sits between the master request ports and the single slave port of the shared-bus fabric.

Parameters:
- N, 4, number of masters (2..16).
- PW, 3, priority width in bits; levels 0..2^PW-1, and a larger value means higher priority.
- RR_TIE, 1, tie-break mode: 1 = round-robin among highest-priority ties, 0 = lowest index wins.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-master request, level-sensitive.
- prio  in  N*PW  packed priorities; master i uses bits [i*PW +: PW].
- last  in  N  per-master last-beat flag, qualified by s_ready.
- s_ready  in  1  slave accepts the current beat.
- gnt  out  N  one-hot grant, registered.
- gnt_vld  out  1  a grant is active; equals |gnt.
- gnt_id  out  $clog2(N)  index of the granted master; 0 when idle.
- gnt_prio  out  PW  priority latched at grant time; 0 when idle.

Behaviour:
- Reset: the asynchronous, active-low reset is decided and fixed. Reset forces all of the following:
  - gnt=0, gnt_vld=0, gnt_id=0, gnt_prio=0.
  - rr_ptr=0.
  - state=IDLE.
- State machine with two states, IDLE and BUSY.
- Candidate set: masters with req=1.
  - maxp = maximum prio over the candidate set.
  - winners = candidates with prio==maxp.
- Selection when RR_TIE=1: the first winner at index >= rr_ptr, searching upward with wrap-around modulo N.
- Selection when RR_TIE=0: the lowest-index winner. rr_ptr is ignored but still updated.
- IDLE:
  - If |req, select a winner and load gnt, gnt_id and gnt_prio on the next edge. Go to BUSY. Latency is 1 cycle from req to gnt.
  - Otherwise stay in IDLE with outputs held at 0.
- BUSY: owner = gnt_id. The grant is locked; prio changes and higher-priority requests do NOT preempt it.
- Release condition: (s_ready & last[owner]), or req[owner]==0.
- On release:
  - rr_ptr <= (owner+1) mod N.
  - Re-arbitrate in the same cycle using the updated pointer value, computed combinationally as owner+1.
  - The owner participates only if req[owner] is still 1.
  - If a winner exists, the new grant appears on the next edge with no idle gap; stay in BUSY.
  - If no winner exists, go to IDLE and clear the outputs.
- Without release: hold all outputs and rr_ptr.
- last without s_ready has no effect.
- req[owner] dropping mid-transfer releases the grant even if last was never seen.
- A single requester regranted back-to-back after a release with req still high gets a new grant on the next edge. gnt stays 1, because re-grant to the same master is allowed.
- Priority values equal to 0 are valid requests; they are not masked.
- Invariants, checked with assertions:
  - gnt is $onehot0.
  - gnt_vld == |gnt.
  - gnt[gnt_id] == gnt_vld.
  - Any gnt bit is set only where req was 1 in the arbitration cycle.
- Reset asserted mid-transfer: outputs are cleared asynchronously. After deassertion, arbitration restarts from rr_ptr=0.
- Width rule: gnt_id is $clog2(N) bits. N is not required to be a power of two; pointer wrap-around uses compare-to-N-1, not bit truncation.

Decomposition:
- arb_pkg holds:
  - the state_e enum {IDLE, BUSY};
  - the function onehot_to_idx;
  - the function max_prio for the N*PW vector.
- One sub-module, prio_rr_pick: purely combinational. Inputs are req, prio and ptr; outputs are the valid flag and the winner index. It is instantiated once. The top level holds the FSM, rr_ptr and the output registers.

Test Plan (N=4, PW=3, RR_TIE=1 unless stated):
- Strict priority: req=4'b1111, prio={P3=2,P2=7,P1=5,P0=1} -> one cycle later gnt=4'b0100, gnt_id=2, gnt_prio=7.
- Round-robin ties:
  - Setup: req=4'b1011, all prio=6, last pulsed with s_ready=1 on each grant.
  - Required grant sequence: ids 0,1,3,0,1,3, with no idle cycles between them.
  - With RR_TIE=0 the same stimulus gives ids 0,0,0,...
- Lock, no preemption:
  - Setup: grant to master 1 (prio=2). Then assert req[3] with prio=7 while s_ready=0.
  - gnt must stay 4'b0010 until last[1]&s_ready.
  - Master 3 is granted on the next edge after that.
- Request-drop release:
  - Setup: master 0 granted; it drops req[0] without last, while req[2] is high.
  - gnt=4'b0100 one cycle later; rr_ptr=1.
- Reset mid-transfer:
  - Setup: rst_n pulled low asynchronously between edges while gnt=4'b1000.
  - gnt, gnt_vld and gnt_id go to 0 immediately.
  - After release with req=4'b1111 and equal priorities, the first grant is id 0.
- Idle/boundary:
  - req=0 for 10 cycles -> gnt_vld=0 throughout.
  - last asserted with s_ready=0 for 5 cycles -> no release.
  - prio all 0 with req=4'b0001 -> gnt=4'b0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the priority / round-robin arbiter.
// Helpers work on maximum-size vectors; callers zero-extend into them.
package arb_pkg;

  localparam int unsigned MAX_N  = 16;
  localparam int unsigned MAX_PW = 8;
  localparam int unsigned MAX_IW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Index of the set bit of a one-hot (or zero) vector.
  function automatic logic [MAX_IW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_IW'(i);
    end
    return idx;
  endfunction

  // Highest pw-bit priority among the first n requesting masters.
  function automatic logic [MAX_PW-1:0] max_prio(
    input logic [MAX_N-1:0]        req,
    input logic [MAX_N*MAX_PW-1:0] prio,
    input int unsigned             n,
    input int unsigned             pw
  );
    logic [MAX_PW-1:0]        best;
    logic [MAX_PW-1:0]        fld;
    logic [MAX_N*MAX_PW-1:0]  mask;
    best = '0;
    mask = ((MAX_N*MAX_PW)'(1) << pw) - (MAX_N*MAX_PW)'(1);
    for (int unsigned i = 0; i < MAX_N; i++) begin
      fld = MAX_PW'((prio >> (i * pw)) & mask);
      if ((i < n) && req[i] && (fld > best)) best = fld;
    end
    return best;
  endfunction

endpackage

// File: rtl/prio_rr_pick.sv
// Combinational winner selection: highest priority, ties broken by
// lowest index or by first winner at/after ptr with wrap-around.
module prio_rr_pick #(
  parameter  int unsigned N      = 4,
  parameter  int unsigned PW     = 3,
  parameter  int unsigned RR_TIE = 1,
  localparam int unsigned IW     = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N*PW-1:0] prio,
  input  logic [IW-1:0]   ptr,
  output logic            vld_c,
  output logic [IW-1:0]   idx_c
);
  import arb_pkg::*;

  logic [PW-1:0] maxp;
  logic [N-1:0]  win;
  logic [N-1:0]  sel;
  logic          found;
  int unsigned   j;

  always_comb begin
    maxp  = PW'(max_prio(MAX_N'(req), (MAX_N*MAX_PW)'(prio), N, PW));
    win   = '0;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      win[i] = req[i] && (prio[i*PW +: PW] == maxp);
    end
    // Lowest-index mode is a round-robin search anchored at zero.
    for (int k = 0; k < N; k++) begin
      j = (RR_TIE != 0) ? (32'(ptr) + 32'(k)) : 32'(k);
      if (j >= N) j = j - N;
      if (!found && win[IW'(j)]) begin
        sel[IW'(j)] = 1'b1;
        found       = 1'b1;
      end
    end
    vld_c = found;
    idx_c = IW'(onehot_to_idx(MAX_N'(sel)));
  end

endmodule

// File: rtl/prio_rr_arb.sv
// N-master priority arbiter with locked grants and optional round-robin
// tie-break; grant outputs are registered.
module prio_rr_arb #(
  parameter  int unsigned N      = 4,
  parameter  int unsigned PW     = 3,
  parameter  int unsigned RR_TIE = 1,
  localparam int unsigned IW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*PW-1:0] prio,
  input  logic [N-1:0]    last,
  input  logic            s_ready,
  output logic [N-1:0]    gnt,
  output logic            gnt_vld,
  output logic [IW-1:0]   gnt_id,
  output logic [PW-1:0]   gnt_prio
);
  import arb_pkg::*;

  state_e        state, state_d;
  logic [IW-1:0] rr_ptr, rr_ptr_d;
  logic [IW-1:0] pick_ptr, pick_idx, owner_nxt;
  logic          pick_vld, release_c;
  logic [N-1:0]  gnt_d;
  logic          gnt_vld_d;
  logic [IW-1:0] gnt_id_d;
  logic [PW-1:0] gnt_prio_d, pick_prio;

  prio_rr_pick #(
    .N      (N),
    .PW     (PW),
    .RR_TIE (RR_TIE)
  ) u_pick (
    .req   (req),
    .prio  (prio),
    .ptr   (pick_ptr),
    .vld_c (pick_vld),
    .idx_c (pick_idx)
  );

  // Owner bookkeeping; wrap compares against N-1 so non-power-of-two N works.
  always_comb begin
    owner_nxt = (gnt_id == IW'(N-1)) ? '0 : gnt_id + IW'(1);
    release_c = !req[gnt_id] || (s_ready && last[gnt_id]);
    pick_prio = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == IW'(i)) pick_prio = prio[i*PW +: PW];
    end
  end

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    gnt_d      = gnt;
    gnt_vld_d  = gnt_vld;
    gnt_id_d   = gnt_id;
    gnt_prio_d = gnt_prio;
    pick_ptr   = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_d    = BUSY;
          gnt_d      = N'(1) << pick_idx;
          gnt_vld_d  = 1'b1;
          gnt_id_d   = pick_idx;
          gnt_prio_d = pick_prio;
        end
      end
      BUSY: begin
        // Locked until release; re-arbitration uses the advanced pointer.
        if (release_c) begin
          pick_ptr = owner_nxt;
          rr_ptr_d = owner_nxt;
          if (pick_vld) begin
            gnt_d      = N'(1) << pick_idx;
            gnt_vld_d  = 1'b1;
            gnt_id_d   = pick_idx;
            gnt_prio_d = pick_prio;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            gnt_vld_d  = 1'b0;
            gnt_id_d   = '0;
            gnt_prio_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      gnt_vld  <= 1'b0;
      gnt_id   <= '0;
      gnt_prio <= '0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      gnt      <= gnt_d;
      gnt_vld  <= gnt_vld_d;
      gnt_id   <= gnt_id_d;
      gnt_prio <= gnt_prio_d;
    end
  end

endmodule

// File: tb/tb_prio_rr_arb.sv
// Directed bench for prio_rr_arb: round-robin and lowest-index instances
// share one stimulus stream.
module tb_prio_rr_arb;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req;
  logic [11:0] prio;
  logic [3:0]  last;
  logic        s_ready;

  logic [3:0] g_rr, g_lo;
  logic       v_rr, v_lo;
  logic [1:0] id_rr, id_lo;
  logic [2:0] p_rr, p_lo;
  logic [3:0] rp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_rr_arb #(.N(4), .PW(3), .RR_TIE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .prio(prio), .last(last),
    .s_ready(s_ready), .gnt(g_rr), .gnt_vld(v_rr), .gnt_id(id_rr), .gnt_prio(p_rr)
  );

  prio_rr_arb #(.N(4), .PW(3), .RR_TIE(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .req(req), .prio(prio), .last(last),
    .s_ready(s_ready), .gnt(g_lo), .gnt_vld(v_lo), .gnt_id(id_lo), .gnt_prio(p_lo)
  );

  function automatic logic [11:0] pv(input int p3, input int p2, input int p1, input int p0);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Structural invariants on both instances, req taken from the arbitration cycle.
  task automatic inv();
    chk("onehot_rr", 32'($onehot0(g_rr)), 32'(1));
    chk("vld_rr", 32'(v_rr), 32'(|g_rr));
    chk("idbit_rr", 32'(g_rr[id_rr]), 32'(v_rr));
    chk("reqonly_rr", 32'(g_rr & ~rp), 32'(0));
    chk("onehot_lo", 32'($onehot0(g_lo)), 32'(1));
    chk("vld_lo", 32'(v_lo), 32'(|g_lo));
    chk("reqonly_lo", 32'(g_lo & ~rp), 32'(0));
  endtask

  task automatic step();
    rp = req;
    @(posedge clk);
    #1;
    inv();
  endtask

  int exp_rr [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    req = '0; prio = '0; last = '0; s_ready = 1'b0; rp = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(g_rr), 32'(0));
    chk("rst_vld", 32'(v_rr), 32'(0));
    chk("rst_id", 32'(id_rr), 32'(0));
    chk("rst_prio", 32'(p_rr), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Strict priority
    req = 4'b1111; prio = pv(2, 7, 5, 1);
    step();
    chk("sp_gnt", 32'(g_rr), 32'h4);
    chk("sp_id", 32'(id_rr), 32'd2);
    chk("sp_prio", 32'(p_rr), 32'd7);
    chk("sp_vld", 32'(v_rr), 32'd1);
    req = '0;
    step();
    chk("sp_idle", 32'(v_rr), 32'd0);

    // Pointer back to zero before the tie sequence
    rst_n = 1'b0; #1; rst_n = 1'b1;

    // Round-robin vs lowest-index ties
    req = 4'b1011; prio = pv(6, 6, 6, 6); last = 4'b1111; s_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_id", 32'(id_rr), 32'(exp_rr[k]));
      chk("rr_vld", 32'(v_rr), 32'd1);
      chk("lo_id", 32'(id_lo), 32'd0);
      chk("lo_gnt", 32'(g_lo), 32'h1);
    end
    req = '0; last = '0; s_ready = 1'b0;
    step();
    chk("rr_end_vld", 32'(v_rr), 32'd0);

    // Lock: higher priority and pending last without s_ready do not release
    req = 4'b0010; prio = pv(0, 0, 2, 0);
    step();
    chk("lk_gnt", 32'(g_rr), 32'h2);
    chk("lk_prio", 32'(p_rr), 32'd2);
    req = 4'b1010; prio = pv(7, 0, 0, 0); last = 4'b0010; s_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("lk_hold_gnt", 32'(g_rr), 32'h2);
      chk("lk_hold_prio", 32'(p_rr), 32'd2);
    end
    s_ready = 1'b1;
    step();
    chk("lk_rel_gnt", 32'(g_rr), 32'h8);
    chk("lk_rel_id", 32'(id_rr), 32'd3);
    chk("lk_rel_prio", 32'(p_rr), 32'd7);
    last = '0; s_ready = 1'b0; req = '0;
    step();
    chk("lk_idle", 32'(v_rr), 32'd0);

    // Request-drop release
    req = 4'b0101; prio = pv(4, 4, 4, 4);
    step();
    chk("rd_gnt0", 32'(g_rr), 32'h1);
    req = 4'b0100;
    step();
    chk("rd_gnt2", 32'(g_rr), 32'h4);
    chk("rd_ptr", 32'(u_rr.rr_ptr), 32'd1);

    // Asynchronous reset mid-transfer
    req = 4'b1000;
    step();
    chk("mr_gnt", 32'(g_rr), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt_clr", 32'(g_rr), 32'h0);
    chk("mr_vld_clr", 32'(v_rr), 32'd0);
    chk("mr_id_clr", 32'(id_rr), 32'd0);
    chk("mr_prio_clr", 32'(p_rr), 32'd0);
    req = 4'b1111; prio = pv(5, 5, 5, 5);
    @(posedge clk); #1;
    chk("mr_in_rst", 32'(g_rr), 32'h0);
    rst_n = 1'b1;
    step();
    chk("mr_first_id", 32'(id_rr), 32'd0);
    chk("mr_first_gnt", 32'(g_rr), 32'h1);

    // Idle stretch
    req = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_vld", 32'(v_rr), 32'd0);
    end

    // Zero priority is a valid request
    prio = '0; req = 4'b0001;
    step();
    chk("p0_gnt", 32'(g_rr), 32'h1);
    chk("p0_id", 32'(id_rr), 32'd0);
    chk("p0_prio", 32'(p_rr), 32'd0);

    // Back-to-back regrant of a single requester
    last = 4'b0001; s_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("b2b_gnt", 32'(g_rr), 32'h1);
      chk("b2b_vld", 32'(v_rr), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
